// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Types and constants for the fetch request tracker.
//   fetch_state_t     : tracker FSM states (IDLE, REQ, RESP).
//   FETCH_PC_INVALID  : all-ones marker for "no PC here"; never a legal fetch
//                       address because fetch PCs are 4-byte aligned.
//   fetch_regs_t      : complete registered state of the tracker.
//   FETCH_REGS_RESET  : value loaded into fetch_regs_t on reset.
// Optional feature macro: RIVER_FETCH_FAULT_EN adds the instr_fault register.
// -----------------------------------------------------------------------------
package fetch_pkg;

  import river_cfg_pkg::*;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } fetch_state_t;

  localparam logic [RISCV_ARCH-1:0] FETCH_PC_INVALID = '1;

  typedef struct packed {
    fetch_state_t            state;
    logic                    boot;          // first IDLE cycle after reset
    logic                    discard;       // drop the response in flight
    logic                    req_valid;
    logic                    resp_ready;
    logic [RISCV_ARCH-1:0]   req_addr;
    logic [RISCV_ARCH-1:0]   requested_pc;
    logic [RISCV_ARCH-1:0]   fetching_pc;
    logic [RISCV_ARCH-1:0]   fetched_pc;
    logic                    instr_valid;
`ifdef RIVER_FETCH_FAULT_EN
    logic                    instr_fault;
`endif
    logic [63:0]             instr;
  } fetch_regs_t;

  localparam fetch_regs_t FETCH_REGS_RESET = '{
    state:        IDLE,
    boot:         1'b1,
    discard:      1'b0,
    req_valid:    1'b0,
    resp_ready:   1'b0,
    req_addr:     '0,
    requested_pc: FETCH_PC_INVALID,
    fetching_pc:  FETCH_PC_INVALID,
    fetched_pc:   FETCH_PC_INVALID,
    instr_valid:  1'b0,
`ifdef RIVER_FETCH_FAULT_EN
    instr_fault:  1'b0,
`endif
    instr:        '0
  };

endpackage : fetch_pkg

// File: rtl/river_cfg_pkg.sv
// -----------------------------------------------------------------------------
// river_cfg_pkg
// Core-wide configuration constants shared by the River pipeline blocks.
//   RISCV_ARCH : architectural register / address width in bits.
// -----------------------------------------------------------------------------
package river_cfg_pkg;

  localparam int RISCV_ARCH = 64;

endpackage : river_cfg_pkg

// File: rtl/fetch_req_tracker.sv
// -----------------------------------------------------------------------------
// fetch_req_tracker
// Issues one ICache instruction request at a time (valid/ready), returns the
// fetched 64-bit word to the decoder, and publishes the requested / fetching /
// fetched PCs used by the branch predictor to avoid duplicate fetches.
//
// Parameters
//   ADDR_W        PC / address width (must equal RISCV_ARCH).
//   RESET_VECTOR  first address requested after reset.
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_flush_pipeline      drop in-flight / pending fetch results
//   i_bp_valid, i_bp_pc   predicted fetch request
//   o_mem_req_valid, i_mem_req_ready, o_mem_addr       ICache request channel
//   i_mem_data_valid, i_mem_data_addr, i_mem_data,
//   i_mem_load_fault, o_mem_resp_ready                 ICache response channel
//   o_requested_pc        presented but not yet accepted (all-ones if none)
//   o_fetching_pc         accepted, awaiting response (all-ones if none)
//   o_fetched_pc          last delivered word address (all-ones if none)
//   o_instr_valid, o_instr  one-cycle delivery strobe and word
//   o_instr_fault         fault flag of delivered word (RIVER_FETCH_FAULT_EN)
// Optional feature macro: RIVER_FETCH_FAULT_EN.
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module fetch_req_tracker
  import river_cfg_pkg::*;
  import fetch_pkg::*;
#(
  parameter int                ADDR_W       = RISCV_ARCH,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 64'h10000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush_pipeline,
  input  logic              i_bp_valid,
  input  logic [ADDR_W-1:0] i_bp_pc,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic              i_mem_data_valid,
  input  logic [ADDR_W-1:0] i_mem_data_addr,
  input  logic [63:0]       i_mem_data,
  input  logic              i_mem_load_fault,
  output logic              o_mem_resp_ready,
  output logic [ADDR_W-1:0] o_requested_pc,
  output logic [ADDR_W-1:0] o_fetching_pc,
  output logic [ADDR_W-1:0] o_fetched_pc,
  output logic              o_instr_valid,
  output logic [63:0]       o_instr
`ifdef RIVER_FETCH_FAULT_EN
  ,
  output logic              o_instr_fault
`endif
);

  fetch_regs_t r_reg;
  fetch_regs_t r_next;

  always_comb begin
    r_next             = r_reg;
    r_next.instr_valid = 1'b0;

    unique case (r_reg.state)
      IDLE: begin
        if (r_reg.boot) begin
          // Leaving reset: the very first fetch is the reset vector,
          // regardless of what the predictor is doing.
          r_next.boot         = 1'b0;
          r_next.req_addr     = RESET_VECTOR;
          r_next.requested_pc = RESET_VECTOR;
          r_next.req_valid    = 1'b1;
          r_next.state        = REQ;
        end else if (i_bp_valid) begin
          r_next.req_addr     = i_bp_pc;
          r_next.requested_pc = i_bp_pc;
          r_next.req_valid    = 1'b1;
          r_next.state        = REQ;
        end
      end

      REQ: begin
        // A presented request is never withdrawn; a flush only marks its
        // eventual response for dropping.
        if (i_flush_pipeline) begin
          r_next.discard = 1'b1;
        end
        if (i_mem_req_ready) begin
          r_next.fetching_pc  = r_reg.req_addr;
          r_next.requested_pc = FETCH_PC_INVALID;
          r_next.req_valid    = 1'b0;
          r_next.resp_ready   = 1'b1;
          r_next.state        = RESP;
        end
      end

      RESP: begin
        if (i_mem_data_valid) begin
          // A flush arriving together with the response drops it directly;
          // nothing else is in flight, so discard just clears.
          if (!r_reg.discard && !i_flush_pipeline) begin
            r_next.fetched_pc  = i_mem_data_addr;
            r_next.instr       = i_mem_data;
            r_next.instr_valid = 1'b1;
`ifdef RIVER_FETCH_FAULT_EN
            r_next.instr_fault = i_mem_load_fault;
`endif
          end
          r_next.discard     = 1'b0;
          r_next.fetching_pc = FETCH_PC_INVALID;
          r_next.resp_ready  = 1'b0;
          if (i_bp_valid) begin
            r_next.req_addr     = i_bp_pc;
            r_next.requested_pc = i_bp_pc;
            r_next.req_valid    = 1'b1;
            r_next.state        = REQ;
          end else begin
            r_next.state = IDLE;
          end
        end else if (i_flush_pipeline) begin
          r_next.discard = 1'b1;
        end
      end

      default: begin
        r_next = FETCH_REGS_RESET;
      end
    endcase

    if (i_flush_pipeline) begin
      r_next.fetched_pc = FETCH_PC_INVALID;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_reg <= FETCH_REGS_RESET;
    end else begin
      r_reg <= r_next;
    end
  end

  assign o_mem_req_valid  = r_reg.req_valid;
  assign o_mem_addr       = r_reg.req_addr;
  assign o_mem_resp_ready = r_reg.resp_ready;
  assign o_requested_pc   = r_reg.requested_pc;
  assign o_fetching_pc    = r_reg.fetching_pc;
  assign o_fetched_pc     = r_reg.fetched_pc;
  assign o_instr_valid    = r_reg.instr_valid;
  assign o_instr          = r_reg.instr;

`ifdef RIVER_FETCH_FAULT_EN
  assign o_instr_fault = r_reg.instr_fault;
`else
  // Fault reporting is compiled out; the input is intentionally ignored.
  logic unused_load_fault;
  assign unused_load_fault = i_mem_load_fault;
`endif

endmodule : fetch_req_tracker

// File: tb/tb_fetch_req_tracker.sv
// -----------------------------------------------------------------------------
// tb_fetch_req_tracker
// Self-checking bench for fetch_req_tracker. A vector table describes a chain
// of fetch transactions (flush placement, predictor redirect, ready stalls);
// delivered words are predicted into a scoreboard queue and matched against
// every o_instr_valid strobe. Hand sequences cover reset release and reset
// in RESP. Build with RIVER_FETCH_FAULT_EN to also check o_instr_fault.
// -----------------------------------------------------------------------------
module tb_fetch_req_tracker;

  localparam logic [63:0] ONES = '1;

  logic        clk;
  logic        i_rst;
  logic        i_flush_pipeline;
  logic        i_bp_valid;
  logic [63:0] i_bp_pc;
  logic        o_mem_req_valid;
  logic        i_mem_req_ready;
  logic [63:0] o_mem_addr;
  logic        i_mem_data_valid;
  logic [63:0] i_mem_data_addr;
  logic [63:0] i_mem_data;
  logic        i_mem_load_fault;
  logic        o_mem_resp_ready;
  logic [63:0] o_requested_pc;
  logic [63:0] o_fetching_pc;
  logic [63:0] o_fetched_pc;
  logic        o_instr_valid;
  logic [63:0] o_instr;
`ifdef RIVER_FETCH_FAULT_EN
  logic        o_instr_fault;
`endif

  fetch_req_tracker #(
    .ADDR_W       (64),
    .RESET_VECTOR (64'h10000)
  ) dut (
    .i_clk            (clk),
    .i_rst            (i_rst),
    .i_flush_pipeline (i_flush_pipeline),
    .i_bp_valid       (i_bp_valid),
    .i_bp_pc          (i_bp_pc),
    .o_mem_req_valid  (o_mem_req_valid),
    .i_mem_req_ready  (i_mem_req_ready),
    .o_mem_addr       (o_mem_addr),
    .i_mem_data_valid (i_mem_data_valid),
    .i_mem_data_addr  (i_mem_data_addr),
    .i_mem_data       (i_mem_data),
    .i_mem_load_fault (i_mem_load_fault),
    .o_mem_resp_ready (o_mem_resp_ready),
    .o_requested_pc   (o_requested_pc),
    .o_fetching_pc    (o_fetching_pc),
    .o_fetched_pc     (o_fetched_pc),
    .o_instr_valid    (o_instr_valid),
    .o_instr          (o_instr)
`ifdef RIVER_FETCH_FAULT_EN
    ,
    .o_instr_fault    (o_instr_fault)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] data;
    bit          flush_early;  // flush one cycle before the response
    bit          flush_same;   // flush in the same cycle as the response
    bit          flush_req;    // flush in the cycle the next request is accepted
    bit          fault;
    logic [63:0] next_pc;
    int          idle_wait;    // cycles with i_bp_valid low after the response
    int          ready_wait;   // cycles the next request waits for ready
    bit          exp_strobe;   // response is delivered to the decoder
  } vec_t;

  typedef struct {
    logic [63:0] pc;
    logic [63:0] data;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every delivery strobe must match the oldest predicted word.
  always @(negedge clk) begin
    if (o_instr_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got instr %h pc %h, expected no strobe", o_instr, o_fetched_pc);
      end else begin
        mon_e = sb.pop_front();
        chk("instr_data", o_instr, mon_e.data);
        chk("instr_pc", o_fetched_pc, mon_e.pc);
`ifdef RIVER_FETCH_FAULT_EN
        chk("instr_fault", {63'b0, o_instr_fault}, {63'b0, mon_e.fault});
`endif
      end
    end
  end

  initial begin
    logic [63:0] cur_pc;

    //            data                   fe fs fr ft next_pc      idle rdy strobe
    vecs[0] = '{64'hDEADBEEF00000013, 0, 0, 0, 0, 64'h10008, 0, 5, 1};
    vecs[1] = '{64'h1111111111111111, 1, 0, 0, 0, 64'h30000, 0, 0, 0};
    vecs[2] = '{64'h2222222222222222, 0, 0, 0, 0, 64'h30004, 3, 1, 1};
    vecs[3] = '{64'h3333333333333333, 0, 1, 1, 1, 64'h40000, 0, 0, 0};
    vecs[4] = '{64'h4444444444444444, 0, 0, 0, 0, 64'h40008, 1, 2, 0};
    vecs[5] = '{64'h5555555555555555, 0, 0, 0, 1, 64'h50000, 0, 0, 1};

    i_rst            = 1'b1;
    i_flush_pipeline = 1'b0;
    i_bp_valid       = 1'b0;
    i_bp_pc          = '0;
    i_mem_req_ready  = 1'b0;
    i_mem_data_valid = 1'b0;
    i_mem_data_addr  = '0;
    i_mem_data       = '0;
    i_mem_load_fault = 1'b0;

    repeat (3) tick();
    chk("rst_req_valid", {63'b0, o_mem_req_valid}, 64'd0);
    chk("rst_resp_ready", {63'b0, o_mem_resp_ready}, 64'd0);
    chk("rst_instr_valid", {63'b0, o_instr_valid}, 64'd0);
    chk("rst_instr", o_instr, 64'd0);
    chk("rst_mem_addr", o_mem_addr, 64'd0);
    chk("rst_requested_pc", o_requested_pc, ONES);
    chk("rst_fetching_pc", o_fetching_pc, ONES);
    chk("rst_fetched_pc", o_fetched_pc, ONES);
`ifdef RIVER_FETCH_FAULT_EN
    chk("rst_instr_fault", {63'b0, o_instr_fault}, 64'd0);
`endif

    // Reset release with no predictor request: fetch the reset vector.
    i_rst = 1'b0;
    tick();
    chk("boot_req_valid", {63'b0, o_mem_req_valid}, 64'd1);
    chk("boot_mem_addr", o_mem_addr, 64'h10000);
    tick();
    chk("boot_addr_hold", o_mem_addr, 64'h10000);
    i_mem_req_ready = 1'b1;
    tick();
    i_mem_req_ready = 1'b0;
    chk("boot_fetching_pc", o_fetching_pc, 64'h10000);
    chk("boot_requested_pc", o_requested_pc, ONES);
    chk("boot_req_valid_low", {63'b0, o_mem_req_valid}, 64'd0);
    $display("txn boot: reset vector %h accepted", o_fetching_pc);
    cur_pc = 64'h10000;

    for (int i = 0; i < 6; i++) begin
      chk("resp_fetching_pc", o_fetching_pc, cur_pc);
      chk("resp_ready", {63'b0, o_mem_resp_ready}, 64'd1);

      if (vecs[i].flush_early) begin
        i_flush_pipeline = 1'b1;
        tick();
        i_flush_pipeline = 1'b0;
        chk("flush_fetched_pc", o_fetched_pc, ONES);
        chk("flush_still_resp", {63'b0, o_mem_resp_ready}, 64'd1);
      end

      i_mem_data_valid = 1'b1;
      i_mem_data_addr  = cur_pc;
      i_mem_data       = vecs[i].data;
      i_mem_load_fault = vecs[i].fault;
      i_flush_pipeline = vecs[i].flush_same;
      i_bp_valid       = (vecs[i].idle_wait == 0);
      i_bp_pc          = vecs[i].next_pc;
      if (vecs[i].exp_strobe) sb.push_back('{cur_pc, vecs[i].data, vecs[i].fault});
      tick();
      i_mem_data_valid = 1'b0;
      i_mem_load_fault = 1'b0;
      i_flush_pipeline = 1'b0;
      chk("strobe", {63'b0, o_instr_valid}, {63'b0, vecs[i].exp_strobe});
      chk("resp_fetching_cleared", o_fetching_pc, ONES);

      if (vecs[i].idle_wait > 0) begin
        i_bp_valid = 1'b0;
        for (int k = 0; k < vecs[i].idle_wait; k++) begin
          chk("idle_no_req", {63'b0, o_mem_req_valid}, 64'd0);
          tick();
        end
        i_bp_valid = 1'b1;
        tick();
      end

      chk("req_valid", {63'b0, o_mem_req_valid}, 64'd1);
      chk("req_addr", o_mem_addr, vecs[i].next_pc);
      chk("requested_pc", o_requested_pc, vecs[i].next_pc);
      chk("fetched_pc", o_fetched_pc, vecs[i].exp_strobe ? cur_pc : ONES);

      for (int k = 0; k < vecs[i].ready_wait; k++) begin
        i_bp_valid = 1'b1;
        i_bp_pc    = 64'h20000 + 64'(k * 8);
        tick();
        chk("req_addr_stable", o_mem_addr, vecs[i].next_pc);
      end

      i_mem_req_ready  = 1'b1;
      i_flush_pipeline = vecs[i].flush_req;
      i_bp_valid       = 1'b0;
      tick();
      i_mem_req_ready  = 1'b0;
      i_flush_pipeline = 1'b0;
      chk("accept_fetching_pc", o_fetching_pc, vecs[i].next_pc);
      chk("accept_requested_pc", o_requested_pc, ONES);
      if (vecs[i].flush_req) chk("req_flush_fetched_pc", o_fetched_pc, ONES);

      $display("txn %0d: pc=%h data=%h strobe=%0b next=%h", i, cur_pc, vecs[i].data,
               vecs[i].exp_strobe, vecs[i].next_pc);
      cur_pc = vecs[i].next_pc;
    end

    // Reset while a response is outstanding.
    i_rst = 1'b1;
    tick();
    chk("rst_resp_req_valid", {63'b0, o_mem_req_valid}, 64'd0);
    chk("rst_resp_resp_ready", {63'b0, o_mem_resp_ready}, 64'd0);
    chk("rst_resp_requested", o_requested_pc, ONES);
    chk("rst_resp_fetching", o_fetching_pc, ONES);
    chk("rst_resp_fetched", o_fetched_pc, ONES);
    i_rst = 1'b0;
    tick();
    chk("reboot_mem_addr", o_mem_addr, 64'h10000);
    chk("reboot_req_valid", {63'b0, o_mem_req_valid}, 64'd1);
    $display("txn reset: reissued reset vector %h", o_mem_addr);

    tick();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fetch_req_tracker

// File: doc/fetch_req_tracker.md
# fetch_req_tracker

Fetch-side counterpart of the branch predictor. Accepts the predicted fetch address, issues one instruction request at a time to the ICache through a valid/ready handshake, and returns the fetched 64-bit word to the decoder. It also publishes the requested, fetching and fetched PCs that the predictor compares against to suppress duplicate fetches.

## Interface
Parameters:
- ADDR_W, 64, PC and address width; equals RISCV_ARCH.
- RESET_VECTOR, 64'h10000, first address requested after reset.

Ports:
- i_clk  in  1  CPU clock; all logic is on the rising edge.
- i_rst  in  1  Reset. Synchronous, active-high.
- i_flush_pipeline  in  1  Discard all in-flight and pending fetch results.
- i_bp_valid  in  1  Predictor fetch request valid.
- i_bp_pc  in  ADDR_W  Predicted fetch PC; bits [1:0] are always 0.
- o_mem_req_valid  out  1  ICache request valid.
- i_mem_req_ready  in  1  ICache accepts the request.
- o_mem_addr  out  ADDR_W  ICache request address.
- i_mem_data_valid  in  1  ICache response valid.
- i_mem_data_addr  in  ADDR_W  Response address.
- i_mem_data  in  64  Response data.
- i_mem_load_fault  in  1  Response access fault.
- o_mem_resp_ready  out  1  Ready for an ICache response.
- o_requested_pc  out  ADDR_W  Address presented but not yet accepted.
- o_fetching_pc  out  ADDR_W  Address accepted and awaiting a response.
- o_fetched_pc  out  ADDR_W  Address of the last delivered word.
- o_instr_valid  out  1  One-cycle strobe: new word delivered to the decoder.
- o_instr  out  64  Fetched word.
- o_instr_fault  out  1  Fault flag for the delivered word (RIVER_FETCH_FAULT_EN only).

## Operation
- FSM with three states: IDLE, REQ, RESP.
- IDLE: o_mem_req_valid=0. In the cycle after reset is released, latch req_addr=RESET_VECTOR and go to REQ.
- REQ: o_mem_req_valid=1 and o_mem_addr=req_addr.
  - req_addr is held stable until accepted (handshake rule).
  - On valid&&ready: fetching_pc<=req_addr, requested_pc<=all-ones, go to RESP.
- RESP: o_mem_resp_ready=1. On i_mem_data_valid:
  - If discard=0: fetched_pc<=i_mem_data_addr, o_instr<=i_mem_data, and o_instr_valid pulses for one cycle.
  - If discard=1: no strobe, and discard is cleared.
  - In both cases fetching_pc<=all-ones.
  - If i_bp_valid is high: req_addr<=i_bp_pc, requested_pc<=i_bp_pc, go to REQ. Otherwise go to IDLE-wait (REQ entry is deferred until i_bp_valid).
- While waiting with no request in REQ: if i_bp_valid is low, drop to IDLE. From IDLE with i_bp_valid high, latch i_bp_pc and go to REQ.
- i_flush_pipeline:
  - In REQ or RESP: set discard, fetched_pc<=all-ones.
  - In REQ the pending address is still issued, and its response is dropped.
  - Flush in IDLE: no effect beyond fetched_pc<=all-ones.
- Flush coinciding with a response in RESP: that response is dropped. No new discard is set, because nothing remains in flight.
- PC values are all-ones when invalid, so they never match a real predictor address.

## Timing
- Reset values: o_mem_req_valid=0, o_mem_resp_ready=0, o_instr_valid=0, o_instr=0, o_instr_fault=0, o_mem_addr=0. All three PC outputs are all-ones. State IDLE, discard=0.
- All outputs are registered.
- Latency from response to o_instr_valid is 1 cycle.
- Minimum request-to-request spacing is 2 cycles (accept, then response), with one outstanding request maximum.
- Reset mid-operation returns to IDLE immediately. The ICache is reset by the same i_rst, so no stale response arrives.

## Configuration
- RIVER_FETCH_FAULT_EN defined:
  - i_mem_load_fault is latched with each delivered word onto o_instr_fault.
  - A faulting word still strobes o_instr_valid.
- RIVER_FETCH_FAULT_EN not defined:
  - The o_instr_fault port and its register are absent.
  - i_mem_load_fault is ignored.

## Structure
- river_cfg_pkg supplies RISCV_ARCH.
- New package fetch_pkg holds:
  - the FSM enum fetch_state_t (IDLE, REQ, RESP);
  - the constant FETCH_PC_INVALID (all-ones);
  - the register struct fetch_regs_t with its reset constant.
- Single module, with no sub-module. A two-process style is used: comb computes next state, and seq registers it with synchronous reset.

## Test plan
- Reset release with i_bp_valid=0 -> REQ with o_mem_addr=0x10000. Ready is given 2 cycles later -> o_fetching_pc=0x10000.
- Response data=0xDEADBEEF00000013, addr=0x10000, i_bp_pc=0x10008 -> o_instr_valid for 1 cycle with that data, o_fetched_pc=0x10000, o_requested_pc=0x10008.
- i_mem_req_ready held low for 5 cycles -> o_mem_addr stays 0x10008 while i_bp_pc changes to 0x20000.
- Flush in RESP, then response arrives -> no o_instr_valid, discard cleared. The next request uses i_bp_pc=0x30000 and is delivered normally.
- i_rst asserted in RESP -> next cycle all PCs are all-ones, o_mem_req_valid=0, state IDLE.
- With RIVER_FETCH_FAULT_EN, a response with i_mem_load_fault=1 -> o_instr_valid=1 and o_instr_fault=1 for one cycle.
